mvu_result_reader: RTL and testbench

//  Read-side master for the MVU data-bank read port (rdc_*). Takes a block-read

---
 rtl/mvu_result_reader.sv | 196 +++++++++++++++++++
 tb/tb_mvu_result_reader.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvu_result_reader.sv
// mvu_result_reader: block-read master for the MVU data-bank rdc_* port.
// Define MVU_RDR_STALLCNT_EN to enable the grant-stall counter on stall_cnt.
module mvu_result_reader #(
  parameter int NMVU       = 8,
  parameter int BMVUA      = $clog2(NMVU),
  parameter int BDBANKA    = 15,
  parameter int BDBANKW    = 64,
  parameter int BLENGTH    = 15,
  parameter int RDLAT      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [BMVUA-1:0]          cmd_mvu,
  input  logic [BDBANKA-1:0]        cmd_addr,
  input  logic [BLENGTH-1:0]        cmd_len,
  input  logic [BDBANKA-1:0]        cmd_stride,
  output logic [NMVU-1:0]           rdc_en,
  input  logic [NMVU-1:0]           rdc_grnt,
  output logic [NMVU*BDBANKA-1:0]   rdc_addr,
  input  logic [NMVU*BDBANKW-1:0]   rdc_word,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BDBANKW-1:0]        out_word,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               stall_cnt
);

  localparam int FA = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [BMVUA-1:0]     sel_q, sel_d;
  logic [BDBANKA-1:0]   addr_q, addr_d;
  logic [BDBANKA-1:0]   stride_q, stride_d;
  logic [BLENGTH-1:0]   req_q, req_d;
  logic [BLENGTH-1:0]   ret_q, ret_d;
  logic [RDLAT-1:0]     vld_q, vld_d;
  logic                 done_q, done_d;
  logic [FA-1:0]        wp_q, wp_d, rp_q, rp_d;
  logic [FA:0]          cnt_q, cnt_d;
  logic [BDBANKW:0]     mem_q [FIFO_DEPTH];

  logic                 accept, mvu_bad, credit_ok;
  logic                 en_sel, grnt_sel, gnt;
  logic                 push, pop, last_push;
  logic [BDBANKW-1:0]   word_sel;
  int                   inflight;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < RDLAT; i++) begin
      inflight += int'(vld_q[i]);
    end
  end

  // Credits cover both queued words and reads still in the return pipe.
  assign credit_ok = (int'(cnt_q) + inflight) < FIFO_DEPTH;
  assign en_sel    = (state_q == ISSUE) && credit_ok;
  assign gnt       = en_sel && grnt_sel;
  assign push      = vld_q[RDLAT-1];
  assign pop       = out_valid && out_ready;
  assign last_push = push && (ret_q == BLENGTH'(1));
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign mvu_bad   = int'(cmd_mvu) >= NMVU;

  always_comb begin
    rdc_en   = '0;
    rdc_addr = '0;
    grnt_sel = 1'b0;
    word_sel = '0;
    for (int i = 0; i < NMVU; i++) begin
      if (int'(sel_q) == i) begin
        rdc_en[i] = en_sel;
        rdc_addr[i*BDBANKA +: BDBANKA] = en_sel ? addr_q : '0;
        grnt_sel = rdc_grnt[i];
        word_sel = rdc_word[i*BDBANKW +: BDBANKW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    req_d    = req_q;
    ret_d    = ret_q;
    done_d   = 1'b0;
    vld_d    = RDLAT'({vld_q, gnt});
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_len == '0 || mvu_bad) begin
            done_d = 1'b1;
          end else begin
            state_d  = ISSUE;
            sel_d    = cmd_mvu;
            addr_d   = cmd_addr;
            stride_d = cmd_stride;
            req_d    = cmd_len;
            ret_d    = cmd_len;
          end
        end
      end
      ISSUE: begin
        if (gnt) begin
          addr_d = addr_q + stride_q;
          req_d  = req_q - BLENGTH'(1);
          if (req_q == BLENGTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: ;
      default: state_d = IDLE;
    endcase
    if (push) begin
      ret_d = ret_q - BLENGTH'(1);
      if (last_push) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_comb begin
    wp_d  = wp_q + FA'(push);
    rp_d  = rp_q + FA'(pop);
    cnt_d = cnt_q + (FA+1)'(push) - (FA+1)'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      req_q    <= '0;
      ret_q    <= '0;
      vld_q    <= '0;
      done_q   <= 1'b0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      req_q    <= req_d;
      ret_q    <= ret_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {last_push, word_sel};
  end

  assign out_valid = cnt_q != '0;
  assign {out_last, out_word} = out_valid ? mem_q[rp_q] : '0;
  assign busy = state_q != IDLE;
  assign done = done_q;

`ifdef MVU_RDR_STALLCNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (accept) begin
      stall_d = '0;
    end else if (en_sel && !grnt_sel && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mvu_result_reader.sv
// tb_mvu_result_reader: directed tests with a transaction-level model
// checked against mvu_result_reader outputs every cycle.
module tb_mvu_result_reader;
  localparam int NMVU  = 6;
  localparam int BMVUA = 3;
  localparam int AW    = 15;
  localparam int DW    = 64;
  localparam int LW    = 15;
  localparam int RDLAT = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 cmd_valid, cmd_ready;
  logic [BMVUA-1:0]     cmd_mvu;
  logic [AW-1:0]        cmd_addr;
  logic [LW-1:0]        cmd_len;
  logic [AW-1:0]        cmd_stride;
  logic [NMVU-1:0]      rdc_en, rdc_grnt;
  logic [NMVU*AW-1:0]   rdc_addr;
  logic [NMVU*DW-1:0]   rdc_word;
  logic                 out_valid, out_ready, out_last, busy, done;
  logic [DW-1:0]        out_word;
  logic [31:0]          stall_cnt;

  mvu_result_reader #(
    .NMVU(NMVU), .BMVUA(BMVUA), .BDBANKA(AW), .BDBANKW(DW),
    .BLENGTH(LW), .RDLAT(RDLAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mvu(cmd_mvu), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_stride(cmd_stride),
    .rdc_en(rdc_en), .rdc_grnt(rdc_grnt),
    .rdc_addr(rdc_addr), .rdc_word(rdc_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_last(out_last),
    .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    else
      n_pass++;
  endfunction

  function automatic logic [63:0] dat(int m, logic [14:0] a);
    logic [7:0] mb;
    mb = 8'(m);
    return {mb, 8'h5A, 16'hC0DE, 17'd0, a};
  endfunction

  // Model state: pending request addresses, expected output stream,
  // grant history for the fixed return latency.
  logic [AW-1:0] exp_addr[$];
  logic [64:0]   exp_out[$];
  logic [AW-1:0] glog[$];
  bit            hv[RDLAT];
  logic [AW-1:0] ha[RDLAT];
  int            hm[RDLAT];
  int  cyc = 0, done_at = -1, cur_mvu = 0, ret_left = 0, outstanding = 0;
  bit  active = 0, pend = 0, en_exp = 0, g_now = 0;
  int  gmode = 0, rdy_mode = 1;
  longint stall_m = 0;
  int  obs_words, obs_last, done_cnt, done_cyc, acc_cyc, en_cycles;
  logic [63:0] obs_first;

  task automatic clr_stats();
    glog.delete();
    obs_words = 0; obs_last = 0; done_cnt = 0;
    done_cyc = -1; acc_cyc = -1; en_cycles = 0;
    obs_first = '0;
  endtask

  task automatic check_outputs();
    logic [NMVU-1:0]    e_en;
    logic [NMVU*AW-1:0] e_ad;
    en_exp = (exp_addr.size() > 0) && (outstanding < DEPTH);
    e_en = '0;
    e_ad = '0;
    if (en_exp) begin
      e_en[cur_mvu] = 1'b1;
      e_ad[cur_mvu*AW +: AW] = exp_addr[0];
    end
    chk("rdc_en", rdc_en, e_en);
    chk("rdc_addr", rdc_addr, e_ad);
    chk("cmd_ready", cmd_ready, !active);
    chk("busy", busy, active);
    chk("done", done, cyc == done_at);
    chk("out_valid", out_valid, exp_out.size() > 0);
    if (exp_out.size() > 0) begin
      chk("out_word", out_word, exp_out[0][63:0]);
      chk("out_last", out_last, exp_out[0][64]);
    end
`ifdef MVU_RDR_STALLCNT_EN
    chk("stall_cnt", stall_cnt, stall_m);
`else
    chk("stall_cnt", stall_cnt, 0);
`endif
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rdc_en != '0) en_cycles++;
  endtask

  task automatic drive_inputs();
    bit gs;
    cmd_valid = pend;
    if (rdy_mode == 2) out_ready = ($urandom_range(1) != 0);
    else               out_ready = (rdy_mode == 1);
    if (gmode == 0)      gs = 1'b1;
    else if (gmode == 1) gs = (cyc % 2) == 0;
    else                 gs = ($urandom_range(1) != 0);
    rdc_grnt = 6'($urandom());
    rdc_grnt[cur_mvu] = gs;
    g_now = gs;
    for (int m = 0; m < NMVU; m++)
      rdc_word[m*DW +: DW] = 64'hDEAD_BEEF_0000_0000 | 64'(m);
    if (hv[RDLAT-1])
      rdc_word[hm[RDLAT-1]*DW +: DW] = dat(hm[RDLAT-1], ha[RDLAT-1]);
  endtask

  task automatic update_model();
    bit g, act_now, lst;
    act_now = active;
    g = en_exp && g_now;
    if (en_exp && !g_now) stall_m++;
    if (exp_out.size() > 0 && out_ready) begin
      obs_words++;
      if (obs_words == 1) obs_first = out_word;
      if (out_last) obs_last = obs_words;
      void'(exp_out.pop_front());
      outstanding--;
    end
    if (hv[RDLAT-1]) begin
      lst = (ret_left == 1);
      exp_out.push_back({lst, dat(hm[RDLAT-1], ha[RDLAT-1])});
      if (lst) begin
        done_at = cyc + 1;
        active = 0;
      end
      ret_left--;
    end
    for (int k = RDLAT - 1; k > 0; k--) begin
      hv[k] = hv[k-1]; ha[k] = ha[k-1]; hm[k] = hm[k-1];
    end
    hv[0] = g;
    if (g) begin
      ha[0] = exp_addr.pop_front();
      hm[0] = cur_mvu;
      glog.push_back(ha[0]);
      outstanding++;
    end
    if (cmd_valid && !act_now) begin
      pend = 0;
      acc_cyc = cyc;
      stall_m = 0;
      if (cmd_len == '0 || int'(cmd_mvu) >= NMVU) begin
        done_at = cyc + 1;
      end else begin
        active = 1;
        cur_mvu = int'(cmd_mvu);
        ret_left = int'(cmd_len);
        for (int i = 0; i < int'(cmd_len); i++)
          exp_addr.push_back(AW'(int'(cmd_addr) + i * int'(cmd_stride)));
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    drive_inputs();
    update_model();
    cyc++;
  endtask

  function automatic bit busy_model();
    return pend || active || exp_out.size() > 0 || cyc <= done_at;
  endfunction

  task automatic run_idle(int budget);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (busy_model() && n < budget);
    chk("run_idle", busy_model(), 0);
  endtask

  task automatic send(int m, int a, int l, int s);
    cmd_mvu = 3'(m);
    cmd_addr = 15'(a);
    cmd_len = 15'(l);
    cmd_stride = 15'(s);
    pend = 1;
  endtask

  task automatic model_reset();
    exp_addr.delete();
    exp_out.delete();
    for (int k = 0; k < RDLAT; k++) hv[k] = 0;
    outstanding = 0; active = 0; pend = 0;
    done_at = -1; stall_m = 0; ret_left = 0;
  endtask

  logic [14:0] t1e[4];
  logic [14:0] t4e[4];

  initial begin
    rst = 1'b1;
    cmd_valid = 0; cmd_mvu = '0; cmd_addr = '0; cmd_len = '0; cmd_stride = '0;
    rdc_grnt = '0; rdc_word = '0; out_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_rdc_en", rdc_en, 0);
    chk("rst_rdc_addr", rdc_addr, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    // T1: basic burst on MVU 3
    clr_stats();
    gmode = 0; rdy_mode = 1;
    send(3, 'h10, 4, 1);
    run_idle(100);
    t1e = '{15'h10, 15'h11, 15'h12, 15'h13};
    chk("t1_ngrant", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      chk("t1_addr", glog[i], t1e[i]);
    chk("t1_words", obs_words, 4);
    chk("t1_last_idx", obs_last, 4);
    chk("t1_first_word", obs_first, 64'h035A_C0DE_0000_0010);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_after", busy, 0);

    // T2: host stalled, credits limit outstanding reads
    clr_stats();
    rdy_mode = 0;
    send(0, 'h100, 8, 2);
    repeat (20) cycle();
    chk("t2_grants_stalled", glog.size(), DEPTH);
    chk("t2_en_low", rdc_en, 0);
    rdy_mode = 1;
    run_idle(200);
    chk("t2_grants", glog.size(), 8);
    chk("t2_words", obs_words, 8);
    chk("t2_last_idx", obs_last, 8);

    // T3: toggling grant on MVU 5
    clr_stats();
    gmode = 1;
    send(5, 'h200, 6, 3);
    run_idle(200);
    chk("t3_words", obs_words, 6);
    chk("t3_grants", glog.size(), 6);

    // T4: address wrap
    clr_stats();
    gmode = 0;
    send(1, 'h7FFE, 4, 1);
    run_idle(100);
    t4e = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
    chk("t4_ngrant", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      chk("t4_addr", glog[i], t4e[i]);

    // T5: zero length, then out-of-range MVU
    clr_stats();
    send(2, 'h55, 0, 1);
    run_idle(20);
    chk("t5a_done_lat", done_cyc - acc_cyc, 1);
    chk("t5a_no_en", en_cycles, 0);
    chk("t5a_no_words", obs_words, 0);
    chk("t5a_done_cnt", done_cnt, 1);
    clr_stats();
    send(NMVU, 'h55, 3, 1);
    run_idle(20);
    chk("t5b_done_lat", done_cyc - acc_cyc, 1);
    chk("t5b_no_en", en_cycles, 0);
    chk("t5b_no_words", obs_words, 0);

    // T7: random ready and grant, striding with wrap
    clr_stats();
    gmode = 2; rdy_mode = 2;
    send(2, 'h3000, 10, 'h1234);
    run_idle(400);
    chk("t7_words", obs_words, 10);
    chk("t7_last_idx", obs_last, 10);

    // T6: reset mid-transfer
    clr_stats();
    gmode = 0; rdy_mode = 1;
    send(4, 0, 16, 1);
    repeat (8) cycle();
    rst = 1'b1;
    cmd_valid = 0;
    #1;
    chk("t6_rdc_en", rdc_en, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_word", out_word, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_cmd_ready", cmd_ready, 0);
    chk("t6_stall", stall_cnt, 0);
    model_reset();
    @(negedge clk);
    chk("t6_out_valid2", out_valid, 0);
    chk("t6_rdc_en2", rdc_en, 0);
    rst = 1'b0;
    clr_stats();
    send(2, 'h40, 3, 1);
    run_idle(100);
    chk("t6_words", obs_words, 3);
    chk("t6_grants", glog.size(), 3);
    chk("t6_done_cnt", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
